// File: rtl/nrisc_data_mem_if.sv
// Request/response bus between the NRISC core (master) and its data memory (slave).
// Requests are level signals held until MEM_ready; MEM_ready/MEM_err are one-cycle strobes.
interface nrisc_data_mem_if #(
   parameter int TAM = 16
);
   logic [TAM-1:0] CORE_DATA_ADDR;
   logic [TAM-1:0] DATA_IN;
   logic           CORE_DATA_write;
   logic           CORE_DATA_load;
   logic [TAM-1:0] DATA_Out;
   logic           MEM_ready;
   logic           MEM_err;

   modport master (
      output CORE_DATA_ADDR,
      output DATA_IN,
      output CORE_DATA_write,
      output CORE_DATA_load,
      input  DATA_Out,
      input  MEM_ready,
      input  MEM_err
   );

   modport slave (
      input  CORE_DATA_ADDR,
      input  DATA_IN,
      input  CORE_DATA_write,
      input  CORE_DATA_load,
      output DATA_Out,
      output MEM_ready,
      output MEM_err
   );
endinterface

// File: rtl/nrisc_data_mem.sv
// Word-addressed data RAM for the NRISC core behind an IDLE/BUSY/RESP wait-state FSM.
// Each access completes with a one-cycle MEM_ready strobe; range and op errors add MEM_err.
module nrisc_data_mem #(
   parameter int TAM        = 16,
   parameter int DEPTH_LOG2 = 8,
   parameter int WAIT       = 1
) (
   input logic               clk,
   input logic               rst,
   nrisc_data_mem_if.slave   bus
);

   localparam int         DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [2:0] WAIT_C = 3'(WAIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_READ    = 2'd0,
      OP_WRITE   = 2'd1,
      OP_ILLEGAL = 2'd2
   } op_t;

   // Any set bit above the RAM index makes the address invalid; no wrap-around.
   function automatic logic addr_in_range(input logic [TAM-1:0] a);
      return (a >> DEPTH_LOG2) == {TAM{1'b0}};
   endfunction

   state_t          state_q, state_d;
   op_t             op_q, op_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [TAM-1:0]  addr_q, addr_d;
   logic [TAM-1:0]  wdata_q, wdata_d;
   logic [TAM-1:0]  data_out_q, data_out_d;
   logic            mem_ready_q, mem_ready_d;
   logic            mem_err_q, mem_err_d;
   logic            ram_we_s;
   logic            in_range_s;
   logic [DEPTH_LOG2-1:0] ram_idx_s;
   logic [TAM-1:0]  ram_q [DEPTH];

   assign in_range_s = addr_in_range(addr_q);
   assign ram_idx_s  = addr_q[DEPTH_LOG2-1:0];

   // Next-state, latch and completion logic for the wait-state FSM.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      data_out_d  = data_out_q;
      mem_ready_d = 1'b0;
      mem_err_d   = 1'b0;
      ram_we_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.CORE_DATA_write && bus.CORE_DATA_load) begin
               op_d    = OP_ILLEGAL;
               addr_d  = bus.CORE_DATA_ADDR;
               wdata_d = bus.DATA_IN;
               cnt_d   = WAIT_C;
               state_d = ST_BUSY;
            end else if (bus.CORE_DATA_write || bus.CORE_DATA_load) begin
               op_d    = bus.CORE_DATA_write ? OP_WRITE : OP_READ;
               addr_d  = bus.CORE_DATA_ADDR;
               wdata_d = bus.DATA_IN;
               cnt_d   = WAIT_C;
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               // Access happens on the same edge that enters RESP, so strobes are registered here.
               state_d     = ST_RESP;
               mem_ready_d = 1'b1;
               case (op_q)
                  OP_WRITE: begin
                     if (in_range_s) begin
                        ram_we_s = 1'b1;
                     end else begin
                        mem_err_d = 1'b1;
                     end
                  end
                  OP_READ: begin
                     if (in_range_s) begin
                        data_out_d = ram_q[ram_idx_s];
                     end else begin
                        data_out_d = {TAM{1'b0}};
                        mem_err_d  = 1'b1;
                     end
                  end
                  OP_ILLEGAL: begin
                     mem_err_d = 1'b1;
                  end
                  default: begin
                     mem_err_d = 1'b1;
                  end
               endcase
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state, latched request and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_READ;
         cnt_q       <= 3'd0;
         addr_q      <= {TAM{1'b0}};
         wdata_q     <= {TAM{1'b0}};
         data_out_q  <= {TAM{1'b0}};
         mem_ready_q <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         data_out_q  <= data_out_d;
         mem_ready_q <= mem_ready_d;
         mem_err_q   <= mem_err_d;
      end
   end

   // RAM array has no reset; reset forces IDLE so an in-flight write never lands.
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         ram_q[ram_idx_s] <= wdata_q;
      end
   end

   assign bus.DATA_Out  = data_out_q;
   assign bus.MEM_ready = mem_ready_q;
   assign bus.MEM_err   = mem_err_q;

endmodule

// File: tb/tb_nrisc_data_mem.sv
// Scoreboard bench for nrisc_data_mem: three instances (WAIT=1, 0, 3) share clock and reset.
module tb_nrisc_data_mem;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] addr_s [3];
   logic [15:0] din_s  [3];
   logic        wr_s   [3];
   logic        ld_s   [3];
   logic [15:0] dout_s [3];
   logic        rdy_s  [3];
   logic        err_s  [3];

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [15:0] data;
      logic        err;
   } exp_t;

   exp_t        sb_q [$];
   logic [15:0] mdl      [3][256];
   logic [15:0] last_out [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      nrisc_data_mem_if #(.TAM(16)) bif ();
      assign bif.CORE_DATA_ADDR  = addr_s[g];
      assign bif.DATA_IN         = din_s[g];
      assign bif.CORE_DATA_write = wr_s[g];
      assign bif.CORE_DATA_load  = ld_s[g];
      assign dout_s[g]           = bif.DATA_Out;
      assign rdy_s[g]            = bif.MEM_ready;
      assign err_s[g]            = bif.MEM_err;
      nrisc_data_mem #(
         .TAM(16), .DEPTH_LOG2(8), .WAIT((g == 0) ? 1 : ((g == 1) ? 0 : 3))
      ) u_dut (
         .clk(clk), .rst(rst), .bus(bif)
      );
   end

   function automatic int wait_of(input int s);
      return (s == 0) ? 1 : ((s == 1) ? 0 : 3);
   endfunction

   // Reference model: computes the expected completion and pushes it to the scoreboard.
   task automatic push_expected(input int s, input logic wr, input logic ld,
                                input logic [15:0] a, input logic [15:0] d);
      exp_t e;
      e.err = 1'b0;
      if (wr && ld) begin
         e.err = 1'b1;
      end else if (a > 16'h00FF) begin
         e.err = 1'b1;
         if (ld) last_out[s] = 16'h0000;
      end else if (wr) begin
         mdl[s][a[7:0]] = d;
      end else begin
         last_out[s] = mdl[s][a[7:0]];
      end
      e.data = last_out[s];
      sb_q.push_back(e);
   endtask

   // One full access: drive, wait for MEM_ready (bounded), pop and compare, check strobe width.
   task automatic access(input int s, input logic wr, input logic ld,
                         input logic [15:0] a, input logic [15:0] d, input string name);
      int   n;
      bit   got;
      exp_t e;
      addr_s[s] = a; din_s[s] = d; wr_s[s] = wr; ld_s[s] = ld;
      push_expected(s, wr, ld, a, d);
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk); got = (rdy_s[s] === 1'b1);
      end
      wr_s[s] = 1'b0; ld_s[s] = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if (!got || n != wait_of(s) + 2)
         $display("FAIL %s latency: got %0d edges (ready seen=%0b), expected %0d", name, n, got, wait_of(s) + 2);
      else passes++;
      checks++;
      if (dout_s[s] !== e.data) $display("FAIL %s DATA_Out: got %h, expected %h", name, dout_s[s], e.data);
      else passes++;
      checks++;
      if (err_s[s] !== e.err) $display("FAIL %s MEM_err: got %b, expected %b", name, err_s[s], e.err);
      else passes++;
      @(posedge clk); @(negedge clk);
      checks++;
      if (rdy_s[s] !== 1'b0 || err_s[s] !== 1'b0)
         $display("FAIL %s strobe width: ready=%b err=%b after response, expected 0 0", name, rdy_s[s], err_s[s]);
      else passes++;
   endtask

   task automatic check_idle_outputs(input string name);
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (dout_s[s] !== 16'h0000 || rdy_s[s] !== 1'b0 || err_s[s] !== 1'b0)
            $display("FAIL %s dut%0d: DATA_Out=%h ready=%b err=%b, expected 0000 0 0", name, s, dout_s[s], rdy_s[s], err_s[s]);
         else passes++;
      end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         addr_s[s] = 16'h0000; din_s[s] = 16'h0000; wr_s[s] = 1'b0; ld_s[s] = 1'b0;
         last_out[s] = 16'h0000;
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_held");
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset_released_idle");
   endtask

   task automatic test_write_read();
      access(0, 1'b1, 1'b0, 16'h0013, 16'h0000, "preload_13");
      access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, "preload_20");
      access(0, 1'b1, 1'b0, 16'h0005, 16'h1111, "preload_05");
      access(0, 1'b1, 1'b0, 16'h0000, 16'hC0DE, "preload_00");
      access(0, 1'b1, 1'b0, 16'h0012, 16'hBEEF, "write_12");
      access(0, 1'b0, 1'b1, 16'h0012, 16'h0000, "read_12");
      access(0, 1'b0, 1'b1, 16'h0013, 16'h0000, "read_13");
   endtask

   task automatic test_out_of_range();
      access(0, 1'b1, 1'b0, 16'h0100, 16'h1234, "oor_write");
      access(0, 1'b0, 1'b1, 16'h0000, 16'h0000, "read_00_after_oor");
      access(0, 1'b0, 1'b1, 16'h0100, 16'h0000, "oor_read");
      access(0, 1'b0, 1'b1, 16'h8000, 16'h0000, "oor_read_msb");
   endtask

   task automatic test_illegal();
      access(0, 1'b0, 1'b1, 16'h0012, 16'h0000, "read_12_before_illegal");
      access(0, 1'b1, 1'b1, 16'h0005, 16'hAAAA, "illegal_req");
      access(0, 1'b0, 1'b1, 16'h0005, 16'h0000, "read_05_after_illegal");
   endtask

   task automatic test_reset_mid();
      addr_s[0] = 16'h0020; din_s[0] = 16'h5555; wr_s[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0; wr_s[0] = 1'b0;
      for (int s = 0; s < 3; s++) last_out[s] = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (rdy_s[0] !== 1'b0) $display("FAIL reset_mid ready: got %b, expected 0", rdy_s[0]);
         else passes++;
      end
      rst = 1'b1;
      @(negedge clk);
      access(0, 1'b0, 1'b1, 16'h0020, 16'h0000, "read_20_after_abort");
   endtask

   task automatic test_back_to_back(input int s, input logic [15:0] a, input logic [15:0] d);
      int   c, prev, pulses;
      exp_t e;
      access(s, 1'b1, 1'b0, a, d, "b2b_preload");
      addr_s[s] = a; ld_s[s] = 1'b1;
      push_expected(s, 1'b0, 1'b1, a, 16'h0000);
      c = 0; prev = 0; pulses = 0;
      while (pulses < 4 && c < 60) begin
         @(posedge clk); c++;
         @(negedge clk);
         if (rdy_s[s] === 1'b1) begin
            e = sb_q.pop_front();
            checks++;
            if (dout_s[s] !== e.data) $display("FAIL b2b dut%0d data: got %h, expected %h", s, dout_s[s], e.data);
            else passes++;
            if (pulses > 0) begin
               checks++;
               if (c - prev != wait_of(s) + 3)
                  $display("FAIL b2b dut%0d spacing: got %0d cycles, expected %0d", s, c - prev, wait_of(s) + 3);
               else passes++;
            end
            prev = c; pulses++;
            if (pulses < 4) push_expected(s, 1'b0, 1'b1, a, 16'h0000);
            else ld_s[s] = 1'b0;
         end
      end
      ld_s[s] = 1'b0;
      checks++;
      if (pulses != 4) $display("FAIL b2b dut%0d pulse count: got %0d, expected 4", s, pulses);
      else passes++;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_drop();
      int   n;
      bit   got;
      exp_t e;
      access(2, 1'b1, 1'b0, 16'h0000, 16'h0A0A, "drop_preload_00");
      addr_s[2] = 16'h0011; din_s[2] = 16'h7E57; wr_s[2] = 1'b1;
      push_expected(2, 1'b1, 1'b0, 16'h0011, 16'h7E57);
      @(posedge clk); @(negedge clk);
      addr_s[2] = 16'h0000; din_s[2] = 16'h0000; wr_s[2] = 1'b0;
      n = 1; got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk); got = (rdy_s[2] === 1'b1);
      end
      e = sb_q.pop_front();
      checks++;
      if (!got || n != 5) $display("FAIL drop latency: got %0d edges (ready seen=%0b), expected 5", n, got);
      else passes++;
      checks++;
      if (err_s[2] !== e.err || dout_s[2] !== e.data)
         $display("FAIL drop response: err=%b data=%h, expected err=%b data=%h", err_s[2], dout_s[2], e.err, e.data);
      else passes++;
      @(posedge clk); @(negedge clk);
      access(2, 1'b0, 1'b1, 16'h0011, 16'h0000, "drop_read_11");
      access(2, 1'b0, 1'b1, 16'h0000, 16'h0000, "drop_read_00");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_out_of_range();
      test_illegal();
      test_reset_mid();
      test_back_to_back(1, 16'h0010, 16'h3C3C);
      test_back_to_back(2, 16'h0010, 16'hA5A5);
      test_back_to_back(0, 16'h00FF, 16'h0F0F);
      test_drop();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
